// File: rtl/spike_window_decoder.sv
// spike_window_decoder
//   Output-side readout for a spiking network. On start it records WINDOW
//   consecutive samples of each spike channel. For each channel it reports
//   the bit pattern, the spike count and the cycle of the first spike. It also
//   reports a winner-take-all class with tie and silence flags. The result is
//   presented over a valid/ready handshake and held stable until accepted.
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         request a capture window (honoured only when idle)
//   spike_in      one spike level per channel
//   busy          capture window in progress
//   result_valid  result fields stable and offered to the consumer
//   result_ready  consumer accepts the result
//   pattern       per-channel trains, channel c at [c*WINDOW +: WINDOW],
//                 with the earliest sample in the MSB
//   count         per-channel spike counts
//   first_spike   per-channel first-spike cycle, WINDOW if the channel is silent
//   winner        lowest channel index holding the maximum count
//   tie           two or more channels share a non-zero maximum
//   no_spike      every channel stayed silent
//
// state   | meaning
// --------+------------------------------------------------
// IDLE    | waiting for start, last result still on outputs
// CAPTURE | sampling spike_in, one sample per cycle
// HOLD    | result_valid high, waiting for result_ready
module spike_window_decoder #(
    parameter int NUM_CH = 2,
    parameter int WINDOW = 40,
    parameter int CNT_W  = $clog2(WINDOW + 1),
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [NUM_CH-1:0]         spike_in,
    output logic                      busy,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [NUM_CH*WINDOW-1:0]  pattern,
    output logic [NUM_CH*CNT_W-1:0]   count,
    output logic [NUM_CH*CNT_W-1:0]   first_spike,
    output logic [IDX_W-1:0]          winner,
    output logic                      tie,
    output logic                      no_spike
);

    localparam int NM_W = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_HOLD    = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cyc_q, cyc_d;
    logic [NUM_CH*WINDOW-1:0]   pattern_q, pattern_d;
    logic [NUM_CH*CNT_W-1:0]    count_q, count_d;
    logic [NUM_CH*CNT_W-1:0]    first_q, first_d;
    logic [IDX_W-1:0]           winner_q, winner_d;
    logic                       tie_q, tie_d;
    logic                       no_spike_q, no_spike_d;

    logic                       last_sample;
    logic [CNT_W-1:0]           max_cnt;
    logic [IDX_W-1:0]           win_idx;
    logic [NM_W-1:0]            n_at_max;

    assign last_sample = (state_q == S_CAPTURE) && (cyc_q == CNT_W'(WINDOW - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start)        state_d = S_CAPTURE;
            S_CAPTURE: if (last_sample)  state_d = S_HOLD;
            S_HOLD:    if (result_ready) state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            S_CAPTURE: busy         = 1'b1;
            S_HOLD:    result_valid = 1'b1;
            default:   ;
        endcase
    end

    // Capture datapath
    always_comb begin
        cyc_d      = cyc_q;
        pattern_d  = pattern_q;
        count_d    = count_q;
        first_d    = first_q;
        if (state_q == S_IDLE && start) begin
            cyc_d     = '0;
            pattern_d = '0;
            count_d   = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                first_d[c*CNT_W +: CNT_W] = CNT_W'(WINDOW);
            end
        end else if (state_q == S_CAPTURE) begin
            cyc_d = cyc_q + CNT_W'(1);
            for (int c = 0; c < NUM_CH; c++) begin
                pattern_d[c*WINDOW +: WINDOW] = {pattern_q[c*WINDOW +: WINDOW-1], spike_in[c]};
                if (spike_in[c]) begin
                    count_d[c*CNT_W +: CNT_W] = count_q[c*CNT_W +: CNT_W] + CNT_W'(1);
                    if (first_q[c*CNT_W +: CNT_W] == CNT_W'(WINDOW)) begin
                        first_d[c*CNT_W +: CNT_W] = cyc_q;
                    end
                end
            end
        end
    end

    // Classification works on the next-state counts so the final sample is
    // included and the flags are ready in the first HOLD cycle.
    always_comb begin
        max_cnt  = '0;
        win_idx  = '0;
        n_at_max = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (count_d[c*CNT_W +: CNT_W] > max_cnt) begin
                max_cnt = count_d[c*CNT_W +: CNT_W];
                win_idx = IDX_W'(c);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (count_d[c*CNT_W +: CNT_W] == max_cnt) begin
                n_at_max = n_at_max + NM_W'(1);
            end
        end
    end

    always_comb begin
        winner_d   = winner_q;
        tie_d      = tie_q;
        no_spike_d = no_spike_q;
        if (last_sample) begin
            winner_d   = win_idx;
            tie_d      = (n_at_max > NM_W'(1)) && (max_cnt != '0);
            no_spike_d = (max_cnt == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q      <= '0;
            pattern_q  <= '0;
            count_q    <= '0;
            first_q    <= '0;
            winner_q   <= '0;
            tie_q      <= 1'b0;
            no_spike_q <= 1'b0;
        end else begin
            cyc_q      <= cyc_d;
            pattern_q  <= pattern_d;
            count_q    <= count_d;
            first_q    <= first_d;
            winner_q   <= winner_d;
            tie_q      <= tie_d;
            no_spike_q <= no_spike_d;
        end
    end

    assign pattern     = pattern_q;
    assign count       = count_q;
    assign first_spike = first_q;
    assign winner      = winner_q;
    assign tie         = tie_q;
    assign no_spike    = no_spike_q;

endmodule

// File: tb/tb_spike_window_decoder.sv
module tb_spike_window_decoder;

    localparam int NUM_CH = 2;
    localparam int WINDOW = 40;
    localparam int CNT_W  = 6;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      start;
    logic [NUM_CH-1:0]         spike_in;
    logic                      busy;
    logic                      result_valid;
    logic                      result_ready;
    logic [NUM_CH*WINDOW-1:0]  pattern;
    logic [NUM_CH*CNT_W-1:0]   count;
    logic [NUM_CH*CNT_W-1:0]   first_spike;
    logic [0:0]                winner;
    logic                      tie;
    logic                      no_spike;

    spike_window_decoder #(.NUM_CH(NUM_CH), .WINDOW(WINDOW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .spike_in     (spike_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .pattern      (pattern),
        .count        (count),
        .first_spike  (first_spike),
        .winner       (winner),
        .tie          (tie),
        .no_spike     (no_spike)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected view of the outputs, maintained by the stimulus tasks
    logic        chk_en = 1'b0;
    logic        chk_fields = 1'b0;
    logic        exp_busy = 1'b0;
    logic        exp_valid = 1'b0;
    logic [79:0] exp_pattern = '0;
    logic [11:0] exp_count = '0;
    logic [11:0] exp_first = '0;
    logic [0:0]  exp_winner = '0;
    logic        exp_tie = 1'b0;
    logic        exp_no_spike = 1'b0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 80'(busy), 80'(exp_busy));
            check("result_valid", 80'(result_valid), 80'(exp_valid));
            if (chk_fields) begin
                check("pattern", pattern, exp_pattern);
                check("count", 80'(count), 80'(exp_count));
                check("first_spike", 80'(first_spike), 80'(exp_first));
                check("winner", 80'(winner), 80'(exp_winner));
                check("tie", 80'(tie), 80'(exp_tie));
                check("no_spike", 80'(no_spike), 80'(exp_no_spike));
            end
        end
    end

    // Reference: summarise two complete 40-sample trains (MSB = first sample)
    task automatic model(input logic [39:0] v0, input logic [39:0] v1);
        logic [39:0] v [2];
        int c [2];
        int f [2];
        v[0] = v0;
        v[1] = v1;
        for (int ch = 0; ch < 2; ch++) begin
            c[ch] = 0;
            f[ch] = WINDOW;
            for (int i = 0; i < WINDOW; i++) begin
                if (v[ch][39-i]) begin
                    c[ch]++;
                    if (f[ch] == WINDOW) f[ch] = i;
                end
            end
        end
        exp_pattern  = {v1, v0};
        exp_count    = {6'(c[1]), 6'(c[0])};
        exp_first    = {6'(f[1]), 6'(f[0])};
        exp_no_spike = (c[0] == 0) && (c[1] == 0);
        exp_winner   = (c[1] > c[0]) ? 1'b1 : 1'b0;
        exp_tie      = (c[0] == c[1]) && (c[0] > 0);
    endtask

    // Runs one window from IDLE and returns one step after the HOLD-entry edge.
    // Called at posedge+1.
    task automatic capture(input logic [39:0] v0, input logic [39:0] v1, input bit noisy);
        start = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        exp_busy   = 1'b1;
        chk_fields = 1'b0;
        for (int i = 0; i < WINDOW; i++) begin
            spike_in     = {v1[39-i], v0[39-i]};
            start        = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            result_ready = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
        end
        start        = 1'b0;
        result_ready = 1'b0;
        spike_in     = '0;
        model(v0, v1);
        exp_busy   = 1'b0;
        exp_valid  = 1'b1;
        chk_fields = 1'b1;
    endtask

    task automatic handshake(input int waits, input bit with_start);
        for (int i = 0; i < waits; i++) begin
            result_ready = 1'b0;
            start        = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        result_ready = 1'b1;
        start        = with_start;
        @(posedge clk); #1;
        result_ready = 1'b0;
        start        = 1'b0;
        exp_valid    = 1'b0;
    endtask

    task automatic lit(input int c0, input int c1, input int f0, input int f1,
                       input int w, input int t, input int ns);
        check("lit_count0", 80'(count[5:0]), 80'(c0));
        check("lit_count1", 80'(count[11:6]), 80'(c1));
        check("lit_first0", 80'(first_spike[5:0]), 80'(f0));
        check("lit_first1", 80'(first_spike[11:6]), 80'(f1));
        check("lit_winner", 80'(winner), 80'(w));
        check("lit_tie", 80'(tie), 80'(t));
        check("lit_no_spike", 80'(no_spike), 80'(ns));
    endtask

    initial begin
        logic [39:0] a0, a1, r0, r1, r2;
        rst_n        = 1'b0;
        start        = 1'b0;
        result_ready = 1'b0;
        spike_in     = '0;
        chk_en       = 1'b1;
        chk_fields   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a window
        start = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        exp_busy   = 1'b1;
        chk_fields = 1'b0;
        for (int i = 0; i < 12; i++) begin
            spike_in = 2'b11;
            @(posedge clk); #1;
        end
        #2;
        rst_n        = 1'b0;
        spike_in     = '0;
        exp_busy     = 1'b0;
        exp_valid    = 1'b0;
        exp_pattern  = '0;
        exp_count    = '0;
        exp_first    = '0;
        exp_winner   = '0;
        exp_tie      = 1'b0;
        exp_no_spike = 1'b0;
        chk_fields   = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed windows with hand-computed expectations
        a0 = 40'b0000000000111110000000000111110000000000;
        a1 = 40'b0000011111000000000011111000000000000000;
        capture(a0, a1, 1'b0);
        lit(10, 10, 10, 5, 0, 1, 0);
        handshake(5, 1'b1);

        a0 = 40'b1111100111110011111001111100111110011111;
        a1 = 40'b0000011000001100000110000011000001100000;
        capture(a0, a1, 1'b1);
        lit(30, 10, 0, 5, 0, 0, 0);
        handshake(1, 1'b0);

        a0 = {20{2'b01}};
        a1 = {20{2'b10}};
        capture(a0, a1, 1'b0);
        lit(20, 20, 1, 0, 0, 1, 0);
        handshake(0, 1'b1);

        capture(40'd0, 40'd0, 1'b1);
        lit(0, 0, 40, 40, 0, 0, 1);
        handshake(2, 1'b0);

        // Channel 1 wins outright
        a0 = 40'h00_0000_0001;
        a1 = 40'h00_0000_0300;
        capture(a0, a1, 1'b0);
        lit(1, 2, 39, 30, 1, 0, 0);
        handshake(0, 1'b0);

        // Randomised windows
        for (int n = 0; n < 24; n++) begin
            r0 = 40'({$urandom(), $urandom()});
            r1 = 40'({$urandom(), $urandom()});
            r2 = 40'({$urandom(), $urandom()});
            case ($urandom_range(0, 3))
                0: begin a0 = r0;           a1 = r1;      end
                1: begin a0 = r0 & r1 & r2; a1 = r1 & r2 & ~r0; end
                2: begin a0 = 40'd0;        a1 = r2 & r0; end
                default: begin a0 = r0;     a1 = {r0[0], r0[39:1]}; end
            endcase
            capture(a0, a1, 1'($urandom_range(0, 1)));
            handshake(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
